divider_period_decoder: RTL
===========================

Name: divider_period_decoder

Overview:
- Receive-side counterpart of the team's loadable frequency divider. Watches the divider's carry-out pulse train and measures the clk-cycle period between rising edges.
- Decodes the period back into the divider load setting {H_L, SW} using period = 512 - {H_L, SW, 5'b00000}.
- Reports lock once the setting is stable. Used for self-check and readback of clock-divider configuration on the board.

Parameters:
- CNT_W, 10, width of the period counter and the period output.
- LOCK_COUNT, 2, number of consecutive identical legal periods required to assert locked (range 1..7).
- TIMEOUT, 600, cycles without a rising edge before a timeout error (must be greater than 512 and less than 2^CNT_W).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous active-low reset; 0 clears all state.
- en  input  1  measurement enable; 0 synchronously forces IDLE and clears outputs.
- pulse_in  input  1  divider carry-out, synchronous to clk.
- period  output  CNT_W  last measured period in clk cycles.
- meas_stb  output  1  one-cycle pulse when period is updated.
- H_L  output  1  decoded load bit 8, valid while locked.
- SW  output  3  decoded load bits 7:5, valid while locked.
- locked  output  1  setting stable and legal.
- err_stb  output  1  one-cycle pulse on an illegal period or a timeout.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, prev=0, period=0, meas_stb=0, H_L=0, SW=0, locked=0, err_stb=0, match=0, last_p=0. Reset mid-measurement discards the partial count.
- Edge detect: prev <= pulse_in every cycle. edge = pulse_in & ~prev. A pulse held high counts once.
- meas_stb and err_stb default to 0 each cycle.
- en=0: state <= IDLE; cnt, period, H_L, SW, locked and match cleared; strobes 0; prev still tracks pulse_in.
- State IDLE: on edge -> MEASURE, cnt <= 0. No strobe, since the first edge only opens the window.
- State MEASURE, no edge:
  - cnt <= cnt+1.
  - If cnt == TIMEOUT-1: err_stb <= 1, locked <= 0, match <= 0, state <= IDLE.
- State MEASURE, on edge:
  - P = cnt+1, computed at CNT_W bits.
  - period <= P, meas_stb <= 1, cnt <= 0, stay in MEASURE.
  - Outputs update on the same clk edge that samples the rising edge.
  - An edge takes priority over a timeout in the same cycle.
- Legality: P legal iff P[4:0]==0 and 32 <= P <= 512.
- Decode: ld = 512 - P (9-bit result); H_L_dec = ld[8], SW_dec = ld[7:5].
- Illegal P: err_stb <= 1, locked <= 0, match <= 0; H_L and SW hold their previous values.
- Legal P equal to last_p: match <= min(match+1, LOCK_COUNT).
- Legal P different from last_p: match <= 1, locked <= 0.
- last_p <= P on every edge.
- Lock: when the updated match reaches LOCK_COUNT and locked=0, then locked <= 1 and H_L/SW <= decoded values, all in the same cycle.
  - While locked, further equal periods keep H_L/SW unchanged.
  - Any differing period drops locked in that cycle.
- The first period after a divider init may be short. The lock filter absorbs it, and it must not leave locked asserted.
- Measurement latency: the period of edge n is reported at edge n. Lock is reached at the earliest LOCK_COUNT periods after the first edge.

Test Plan:
1. Drive a divider model with H_L=0, SW=000 (period 512) -> meas_stb every 512 cycles, period=512, locked=1 at the 2nd measurement, H_L=0, SW=000, no err_stb.
2. H_L=1, SW=111 (period 32) -> period=32, locked with H_L=1, SW=111. Then switch to H_L=1, SW=010 (period 192) -> locked drops on the first 192 period, re-locks on the next, H_L=1, SW=010.
3. Edges 100 cycles apart -> period=100, err_stb pulses each edge, locked stays 0, H_L/SW unchanged.
4. Lock at period 512, then hold pulse_in low -> err_stb exactly 600 cycles after the last edge, locked=0, state IDLE. The next two edges produce no strobe on the first and period restart on the second.
5. pulse_in held high for 3 cycles per period (period 256) -> one edge per period, period=256, locked, H_L=0, SW=000... correction: ld=256 gives H_L=1, SW=000.
6. rst pulsed low mid-count while locked -> all outputs 0 immediately (asynchronous). en=0 for one cycle while locked -> locked=0 next cycle, and re-lock requires LOCK_COUNT fresh periods.

Source files
------------

// File: rtl/divider_period_decoder.sv
// Measures the clk-cycle spacing of rising edges on a divider carry-out and
// decodes it back into the divider load setting {H_L, SW}, with a lock filter.
module divider_period_decoder #(
    parameter int CNT_W      = 10,
    parameter int LOCK_COUNT = 2,
    parameter int TIMEOUT    = 600
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period,
    output logic             meas_stb,
    output logic             H_L,
    output logic [2:0]       SW,
    output logic             locked,
    output logic             err_stb
);

    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(32);
    localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(512);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       LOCK_M  = 3'(LOCK_COUNT);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic [CNT_W-1:0] last_p_reg, last_p_next;
    logic             prev_reg, prev_next;
    logic             meas_stb_reg, meas_stb_next;
    logic             err_stb_reg, err_stb_next;
    logic             locked_reg, locked_next;
    logic             h_l_reg, h_l_next;
    logic [2:0]       sw_reg, sw_next;
    logic [2:0]       match_reg, match_next;

    logic             edge_det;
    logic             p_legal;
    logic [CNT_W-1:0] p_meas;
    logic [3:0]       ld_dec;
    logic [2:0]       match_sat;
    logic [2:0]       match_upd;

    assign edge_det  = pulse_in & ~prev_reg;
    assign p_meas    = cnt_reg + CNT_W'(1);
    assign p_legal   = (p_meas[4:0] == 5'd0) && (p_meas >= P_MIN) && (p_meas <= P_MAX);
    // Load bits 8:5; the low five bits are zero whenever the period is legal.
    assign ld_dec    = 4'((P_MAX - p_meas) >> 5);
    assign match_sat = (match_reg >= LOCK_M) ? LOCK_M : match_reg + 3'd1;

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        period_next   = period_reg;
        last_p_next   = last_p_reg;
        prev_next     = pulse_in;
        meas_stb_next = 1'b0;
        err_stb_next  = 1'b0;
        locked_next   = locked_reg;
        h_l_next      = h_l_reg;
        sw_next       = sw_reg;
        match_next    = match_reg;
        match_upd     = match_reg;

        if (!en) begin
            state_next  = IDLE;
            cnt_next    = '0;
            period_next = '0;
            h_l_next    = 1'b0;
            sw_next     = 3'd0;
            locked_next = 1'b0;
            match_next  = 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // First edge only opens the measurement window.
                    if (edge_det) begin
                        state_next = MEASURE;
                        cnt_next   = '0;
                    end
                end
                MEASURE: begin
                    if (edge_det) begin
                        period_next   = p_meas;
                        meas_stb_next = 1'b1;
                        cnt_next      = '0;
                        last_p_next   = p_meas;
                        if (!p_legal) begin
                            err_stb_next = 1'b1;
                            locked_next  = 1'b0;
                            match_next   = 3'd0;
                        end else begin
                            match_upd = (p_meas == last_p_reg) ? match_sat : 3'd1;
                            match_next = match_upd;
                            if (p_meas != last_p_reg)
                                locked_next = 1'b0;
                            if ((match_upd == LOCK_M) && !locked_reg) begin
                                locked_next = 1'b1;
                                h_l_next    = ld_dec[3];
                                sw_next     = ld_dec[2:0];
                            end
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                        if (cnt_reg == TO_LAST) begin
                            err_stb_next = 1'b1;
                            locked_next  = 1'b0;
                            match_next   = 3'd0;
                            state_next   = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            period_reg   <= '0;
            last_p_reg   <= '0;
            prev_reg     <= 1'b0;
            meas_stb_reg <= 1'b0;
            err_stb_reg  <= 1'b0;
            locked_reg   <= 1'b0;
            h_l_reg      <= 1'b0;
            sw_reg       <= 3'd0;
            match_reg    <= 3'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            period_reg   <= period_next;
            last_p_reg   <= last_p_next;
            prev_reg     <= prev_next;
            meas_stb_reg <= meas_stb_next;
            err_stb_reg  <= err_stb_next;
            locked_reg   <= locked_next;
            h_l_reg      <= h_l_next;
            sw_reg       <= sw_next;
            match_reg    <= match_next;
        end
    end

    assign period   = period_reg;
    assign meas_stb = meas_stb_reg;
    assign err_stb  = err_stb_reg;
    assign locked   = locked_reg;
    assign H_L      = h_l_reg;
    assign SW       = sw_reg;

endmodule
